// File: rtl/sdf_bf2_stage8.sv
// -----------------------------------------------------------------------------
// sdf_bf2_stage8
//   Radix-2 single-path delay-feedback butterfly for the delay-8 stage of a
//   32-point DIF FFT. It works with an external 8-deep complex delay line. The
//   butterfly writes the line through sr_din_* and reads the value written
//   8 shifts earlier through sr_dout_*.
//
//   Each 16-sample group runs in two phases, selected by cnt[3]:
//     FILL : the line stores the incoming samples. The line's previous
//            contents (stored differences) leave through the twiddle multiply.
//     BFLY : the sum goes to the output. The difference goes back into the line.
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous, active-low reset
//   in_valid, din_r/i     input sample stream (32-sample contiguous frames)
//   sr_dout_r/i           delay-line output
//   sr_in_valid           delay-line shift enable
//   sr_din_r/i            delay-line write data
//   out_valid, dout_r/i   registered output stream
//   state_dbg             current FSM state (IDLE=0, FILL_FIRST=1, RUN=2, DRAIN=3)
//
// Stream semantics: there is no back-pressure. A sample transfers on every
// rising edge where its valid is high, and the receiver must take it on that
// edge. out_valid follows the candidate cycle by exactly one clock.
// -----------------------------------------------------------------------------
module sdf_bf2_stage8 #(
    parameter int DW    = 24,
    parameter int TW    = 10,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    input  logic [DW-1:0] sr_dout_r,
    input  logic [DW-1:0] sr_dout_i,
    output logic          sr_in_valid,
    output logic [DW-1:0] sr_din_r,
    output logic [DW-1:0] sr_din_i,
    output logic          out_valid,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic [1:0]    state_dbg
);

    localparam int CW = $clog2(2 * DEPTH);   // group counter width
    localparam int KW = CW - 1;              // twiddle index width
    localparam int PW = DW + TW + 1;         // full-precision product width
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL_FIRST = 2'd1,
        RUN        = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        case (state)
            // The in_valid cycle seen in IDLE is sample 0 of the frame. It is
            // written into the line, so FILL_FIRST starts at cnt=1.
            IDLE: begin
                cnt_nxt = '0;
                if (in_valid) begin
                    state_nxt = FILL_FIRST;
                    cnt_nxt   = CW'(1);
                end
            end
            FILL_FIRST: begin
                if (cnt == LAST) state_nxt = RUN;
            end
            RUN: begin
                // A missing sample on a group boundary ends the stream.
                if (cnt == '0 && !in_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign state_dbg = state;

    // ---------------- Datapath ----------------
    logic          bfly;
    logic [KW-1:0] k;
    assign bfly = cnt[CW-1];
    assign k    = cnt[KW-1:0];

    // A missing input inside a frame counts as zero. DRAIN ignores the input.
    logic [DW-1:0] x_r, x_i;
    assign x_r = (in_valid && state != DRAIN) ? din_r : '0;
    assign x_i = (in_valid && state != DRAIN) ? din_i : '0;

    // W16^k, Q2.8
    logic signed [TW-1:0] w_r, w_i;
    always_comb begin
        w_r = TW'(256);
        w_i = TW'(0);
        case (k)
            3'd0: begin w_r = TW'(256);  w_i = TW'(0);    end
            3'd1: begin w_r = TW'(237);  w_i = TW'(-98);  end
            3'd2: begin w_r = TW'(181);  w_i = TW'(-181); end
            3'd3: begin w_r = TW'(98);   w_i = TW'(-237); end
            3'd4: begin w_r = TW'(0);    w_i = TW'(-256); end
            3'd5: begin w_r = TW'(-98);  w_i = TW'(-237); end
            3'd6: begin w_r = TW'(-181); w_i = TW'(-181); end
            3'd7: begin w_r = TW'(-237); w_i = TW'(-98);  end
            default: begin w_r = TW'(256); w_i = TW'(0); end
        endcase
    end

    // The full-width products include the +128 rounding term. An arithmetic
    // shift by 8 follows. k=0 (256,0) therefore passes the value through exactly.
    logic signed [PW-1:0] a_r, a_i, we_r, we_i, p_r, p_i;
    assign a_r  = PW'($signed(sr_dout_r));
    assign a_i  = PW'($signed(sr_dout_i));
    assign we_r = PW'(w_r);
    assign we_i = PW'(w_i);
    assign p_r  = a_r * we_r - a_i * we_i + PW'(128);
    assign p_i  = a_r * we_i + a_i * we_r + PW'(128);

    logic [DW-1:0] mul_r, mul_i;
    assign mul_r = DW'(p_r >>> 8);
    assign mul_i = DW'(p_i >>> 8);

    // Upstream scaling leaves enough headroom, so DW-bit wrap is intended.
    logic [DW-1:0] sum_r, sum_i, dif_r, dif_i;
    assign sum_r = sr_dout_r + x_r;
    assign sum_i = sr_dout_i + x_i;
    assign dif_r = sr_dout_r - x_r;
    assign dif_i = sr_dout_i - x_i;

    logic [DW-1:0] cand_r, cand_i;
    assign cand_r   = bfly ? sum_r : mul_r;
    assign cand_i   = bfly ? sum_i : mul_i;
    assign sr_din_r = bfly ? dif_r : x_r;
    assign sr_din_i = bfly ? dif_i : x_i;

    // The line shifts in every active cycle, including the IDLE cycle that
    // accepts sample 0. The shift enable is forced low while reset is held,
    // so the line stays still during reset.
    assign sr_in_valid = reset && (state != IDLE || in_valid);

    // ---------------- Output register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else begin
            out_valid <= (state == RUN) || (state == DRAIN);
            if (state != IDLE) begin
                dout_r <= cand_r;
                dout_i <= cand_i;
            end
        end
    end

endmodule

// File: tb/tb_sdf_bf2_stage8.sv
// -----------------------------------------------------------------------------
// tb_sdf_bf2_stage8
//   Bench for sdf_bf2_stage8. It supplies the external 8-deep delay line. Each
//   frame's expected outputs come from a reference butterfly/twiddle model and
//   go onto exp_q. A negedge monitor pops exp_q for every valid output.
// -----------------------------------------------------------------------------
module tb_sdf_bf2_stage8;

    localparam int DW = 24;
    localparam int TW = 10;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam logic [DW-1:0] V1000 = 24'd1000;
    localparam logic [DW-1:0] V926  = 24'd926;
    localparam logic [DW-1:0] VM383 = 24'hFFFE81;   // -383
    localparam logic [DW-1:0] VM926 = 24'hFFFC62;   // -926

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          in_valid = 1'b0;
    logic [DW-1:0] din_r = '0, din_i = '0;
    logic [DW-1:0] sr_dout_r, sr_dout_i, sr_din_r, sr_din_i, dout_r, dout_i;
    logic          sr_in_valid, out_valid;
    logic [1:0]    state_dbg;

    sdf_bf2_stage8 #(.DW(DW), .TW(TW), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .din_r      (din_r),
        .din_i      (din_i),
        .sr_dout_r  (sr_dout_r),
        .sr_dout_i  (sr_dout_i),
        .sr_in_valid(sr_in_valid),
        .sr_din_r   (sr_din_r),
        .sr_din_i   (sr_din_i),
        .out_valid  (out_valid),
        .dout_r     (dout_r),
        .dout_i     (dout_i),
        .state_dbg  (state_dbg)
    );

    // External delay line: sr_dout is the value written 8 shifts earlier.
    logic [DW-1:0] dl_r [8] = '{default: '0};
    logic [DW-1:0] dl_i [8] = '{default: '0};
    always @(posedge clk) begin
        if (sr_in_valid) begin
            for (int j = 7; j > 0; j--) begin
                dl_r[j] <= dl_r[j-1];
                dl_i[j] <= dl_i[j-1];
            end
            dl_r[0] <= sr_din_r;
            dl_i[0] <= sr_din_i;
        end
    end
    assign sr_dout_r = dl_r[7];
    assign sr_dout_i = dl_i[7];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [2*DW-1:0] got,
                            input logic [2*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int tw_re[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int tw_im[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

    logic [DW-1:0] fr_r[32], fr_i[32];
    logic          fr_v[32];

    function automatic logic [2*DW-1:0] cmul(input logic signed [DW-1:0] xr,
                                             input logic signed [DW-1:0] xi,
                                             input int k);
        longint re, im;
        re = longint'(xr) * tw_re[k] - longint'(xi) * tw_im[k];
        im = longint'(xr) * tw_im[k] + longint'(xi) * tw_re[k];
        re = (re + 128) >>> 8;
        im = (im + 128) >>> 8;
        return {re[DW-1:0], im[DW-1:0]};
    endfunction

    function automatic logic [DW-1:0] eff_r(input int i);
        return fr_v[i] ? fr_r[i] : '0;
    endfunction
    function automatic logic [DW-1:0] eff_i(input int i);
        return fr_v[i] ? fr_i[i] : '0;
    endfunction

    task automatic push_expected();
        logic [DW-1:0] s_r, s_i, d_r, d_i;
        for (int g = 0; g < 2; g++) begin
            for (int n = 0; n < 8; n++) begin
                s_r = eff_r(16*g+n) + eff_r(16*g+n+8);
                s_i = eff_i(16*g+n) + eff_i(16*g+n+8);
                exp_q.push_back({s_r, s_i});
            end
            for (int n = 0; n < 8; n++) begin
                d_r = eff_r(16*g+n) - eff_r(16*g+n+8);
                d_i = eff_i(16*g+n) - eff_i(16*g+n+8);
                exp_q.push_back(cmul(d_r, d_i, n));
            end
        end
    endtask

    // ---------------- monitor ----------------
    int run_len = 0, last_run = 0, first_cyc = 0, start_cyc = 0;
    logic [2*DW-1:0] got_out[64];

    always @(negedge clk) begin
        if (!reset) begin
            run_len = 0;
        end else if (out_valid) begin
            if (run_len == 0) first_cyc = cyc;
            if (run_len < 64) got_out[run_len] = {dout_r, dout_i};
            check_eq("q_nonempty", 48'(exp_q.size() != 0), 48'd1);
            if (exp_q.size() != 0)
                check_eq($sformatf("out%0d", run_len), {dout_r, dout_i}, exp_q.pop_front());
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rnd_s();
        int v;
        v = int'($urandom_range(0, 2097151)) - 1048576;
        return DW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        din_r    = rnd_s();
        din_i    = rnd_s();
    endtask

    // mode 0: zeros, 1: constant (100,0), 2: random
    task automatic fill_frame(input int mode);
        for (int i = 0; i < 32; i++) begin
            fr_v[i] = 1'b1;
            fr_r[i] = (mode == 1) ? 24'd100 : (mode == 2) ? rnd_s() : '0;
            fr_i[i] = (mode == 2) ? rnd_s() : '0;
        end
    endtask

    // Drives the first n samples of the current frame. The last in_valid level stays applied.
    task automatic drive_frame(input int n);
        push_expected();
        for (int i = 0; i < n; i++) begin
            if (i == 0) start_cyc = cyc;
            in_valid = fr_v[i];
            din_r    = fr_v[i] ? fr_r[i] : rnd_s();
            din_i    = fr_v[i] ? fr_i[i] : rnd_s();
            step();
        end
    endtask

    task automatic wait_done(input int exp_run);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && state_dbg == ST_IDLE) done = 1'b1;
            else step();
        end
        check_eq("drain_done", 48'(done), 48'd1);
        step();
        step();
        check_eq("run_len", 48'(last_run), 48'(exp_run));
        check_eq("idle_state", 48'(state_dbg), 48'(ST_IDLE));
    endtask

    // ---------------- test sequence ----------------
    int a_start;

    initial begin
        // Reset held low with random inputs
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            din_r = rnd_s();
            din_i = rnd_s();
            step();
            check_eq("rst_out_valid", 48'(out_valid), 48'd0);
            check_eq("rst_dout", {dout_r, dout_i}, 48'd0);
            check_eq("rst_sr_in_valid", 48'(sr_in_valid), 48'd0);
        end
        idle_inputs();
        reset = 1'b1;
        step();
        step();

        // Constant frame
        fill_frame(1);
        drive_frame(32);
        idle_inputs();
        wait_done(32);
        check_eq("const_latency", 48'(first_cyc - start_cyc), 48'd9);

        // Impulse at 0
        fill_frame(0);
        fr_r[0] = V1000;
        drive_frame(32);
        idle_inputs();
        wait_done(32);
        check_eq("imp0_idx0", got_out[0], {V1000, 24'd0});
        check_eq("imp0_idx8", got_out[8], {V1000, 24'd0});

        // Impulse at 1: twiddle k=1
        fill_frame(0);
        fr_r[1] = V1000;
        drive_frame(32);
        idle_inputs();
        wait_done(32);
        check_eq("imp1_idx1", got_out[1], {V1000, 24'd0});
        check_eq("imp1_idx9", got_out[9], {V926, VM383});

        // Impulse at 5: twiddle k=5
        fill_frame(0);
        fr_r[5] = V1000;
        drive_frame(32);
        idle_inputs();
        wait_done(32);
        check_eq("imp5_idx13", got_out[13], {VM383, VM926});

        // Back-to-back random frames
        fill_frame(2);
        drive_frame(32);
        a_start = start_cyc;
        fill_frame(2);
        drive_frame(32);
        idle_inputs();
        wait_done(64);
        check_eq("b2b_latency", 48'(first_cyc - a_start), 48'd9);

        // in_valid dropped at cnt=3 in RUN
        fill_frame(2);
        fr_v[19] = 1'b0;
        drive_frame(32);
        idle_inputs();
        wait_done(32);

        // in_valid high during DRAIN
        fill_frame(2);
        drive_frame(32);
        idle_inputs();                 // drain entry cycle (cnt=0)
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            din_r = rnd_s();
            din_i = rnd_s();
            step();
        end
        idle_inputs();
        step();
        step();
        check_eq("drain_state_c7", 48'(state_dbg), 48'(ST_DRAIN));
        step();
        check_eq("drain_idle_c8", 48'(state_dbg), 48'(ST_IDLE));
        wait_done(32);

        // Reset asserted mid-RUN
        fill_frame(2);
        drive_frame(20);
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", 48'(out_valid), 48'd0);
        check_eq("midrst_dout", {dout_r, dout_i}, 48'd0);
        check_eq("midrst_sr_in_valid", 48'(sr_in_valid), 48'd0);
        check_eq("midrst_state", 48'(state_dbg), 48'(ST_IDLE));
        exp_q.delete();
        step();
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        fill_frame(2);
        drive_frame(32);
        idle_inputs();
        wait_done(32);
        check_eq("postrst_latency", 48'(first_cyc - start_cyc), 48'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
